// File: rtl/cache_req_if.sv
// Cache request/response port bundle: one val/rdy request channel and one
// val/rdy response channel. The generator uses the master side.
interface cache_req_if;
    logic [75:0] cachereq_msg;
    logic        cachereq_val;
    logic        cachereq_rdy;
    logic [43:0] cacheresp_msg;
    logic        cacheresp_val;
    logic        cacheresp_rdy;

    modport master (
        output cachereq_msg,
        output cachereq_val,
        input  cachereq_rdy,
        input  cacheresp_msg,
        input  cacheresp_val,
        output cacheresp_rdy
    );

    modport slave (
        input  cachereq_msg,
        input  cachereq_val,
        output cachereq_rdy,
        output cacheresp_msg,
        output cacheresp_val,
        input  cacheresp_rdy
    );
endinterface

// File: rtl/cache_req_traffic_gen.sv
// Bounded cache request generator for one port: issues NUM_REQ val/rdy
// requests along a tag/index sweep, caps requests in flight, checks that
// response opaques come back in order and keeps run statistics.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ISSUE  | presenting a request (val drops while the in-flight cap is reached)
// GAP    | idle cycles between an accepted request and the next one
// DRAIN  | all requests issued, waiting for outstanding responses
// DONE   | run complete, late responses still drained, waiting for start
module cache_req_traffic_gen #(
    parameter int NUM_REQ         = 50,
    parameter int MAX_OUTSTANDING = 4,
    parameter int GAP             = 3,
    parameter int OFFSET_BITS     = 4,
    parameter int IDX_BITS        = 3,
    parameter int TAG_BITS        = 3,
    parameter int TAGS_PER_IDX    = 4,
    parameter int IDX_WRAP        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    cache_req_if.master       bus,
    output logic              busy,
    output logic              done,
    output logic [15:0]       req_cnt,
    output logic [15:0]       resp_cnt,
    output logic [7:0]        err_cnt,
    output logic [31:0]       cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0]         LAST_SEQ = 16'(NUM_REQ - 1);
    localparam logic [7:0]          MAX_OUT  = 8'(MAX_OUTSTANDING);
    localparam logic [7:0]          GAP_LOAD = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TAG_BITS-1:0] TAG_LAST = TAG_BITS'(TAGS_PER_IDX - 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(IDX_WRAP - 1);

    state_t              state_q, state_d;
    logic [15:0]         seq_q, seq_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [7:0]          outstanding_q, outstanding_d;
    logic [7:0]          gap_q, gap_d;
    logic                mode_q, mode_d;
    logic [75:0]         msg_q, msg_d;
    logic [15:0]         req_cnt_q, req_cnt_d;
    logic [15:0]         resp_cnt_q, resp_cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [31:0]         cycle_cnt_q, cycle_cnt_d;

    logic        req_val;
    logic        resp_rdy;
    logic        req_fire;
    logic        resp_fire;
    logic        resp_dec;
    logic        resp_bad;
    logic        busy_w;
    logic [31:0] addr_d;
    logic [1:0]  type_d;

    // Response type, len and data carry nothing the in-order check needs.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{bus.cacheresp_msg[43:42], bus.cacheresp_msg[33:0]};

    // Register all run state; reset returns straight to the idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            seq_q         <= '0;
            tag_q         <= '0;
            idx_q         <= '0;
            outstanding_q <= '0;
            gap_q         <= '0;
            mode_q        <= 1'b0;
            msg_q         <= '0;
            req_cnt_q     <= '0;
            resp_cnt_q    <= '0;
            err_cnt_q     <= '0;
            cycle_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            tag_q         <= tag_d;
            idx_q         <= idx_d;
            outstanding_q <= outstanding_d;
            gap_q         <= gap_d;
            mode_q        <= mode_d;
            msg_q         <= msg_d;
            req_cnt_q     <= req_cnt_d;
            resp_cnt_q    <= resp_cnt_d;
            err_cnt_q     <= err_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
        end
    end

    // Next state, sweep, in-flight tracking, response check and counters.
    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        outstanding_d = outstanding_q;
        gap_d         = gap_q;
        mode_d        = mode_q;
        req_cnt_d     = req_cnt_q;
        resp_cnt_d    = resp_cnt_q;
        err_cnt_d     = err_cnt_q;
        cycle_cnt_d   = cycle_cnt_q;

        busy_w    = (state_q == S_ISSUE) || (state_q == S_GAP) || (state_q == S_DRAIN);
        req_val   = (state_q == S_ISSUE) && (outstanding_q < MAX_OUT);
        resp_rdy  = (state_q != S_IDLE);
        req_fire  = req_val && bus.cachereq_rdy;
        resp_fire = bus.cacheresp_val && resp_rdy;
        // A response with nothing in flight is an error and must not underflow.
        resp_dec  = resp_fire && (outstanding_q != 8'd0);
        resp_bad  = resp_fire && ((outstanding_q == 8'd0) ||
                                  (bus.cacheresp_msg[41:34] != resp_cnt_q[7:0]));

        if (req_fire) begin
            seq_d     = seq_q + 16'd1;
            req_cnt_d = req_cnt_q + 16'd1;
            if (tag_q == TAG_LAST) begin
                tag_d = '0;
                if (idx_q == IDX_LAST) idx_d = '0;
                else                   idx_d = idx_q + 1'b1;
            end else begin
                tag_d = tag_q + 1'b1;
            end
        end

        outstanding_d = outstanding_q + {7'd0, req_fire} - {7'd0, resp_dec};

        if (resp_fire) resp_cnt_d = resp_cnt_q + 16'd1;
        if (resp_bad && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
        if (busy_w && (cycle_cnt_q != 32'hffff_ffff)) cycle_cnt_d = cycle_cnt_q + 32'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_ISSUE;
                    seq_d         = '0;
                    tag_d         = '0;
                    idx_d         = '0;
                    outstanding_d = '0;
                    gap_d         = '0;
                    mode_d        = mode;
                    req_cnt_d     = '0;
                    resp_cnt_d    = '0;
                    err_cnt_d     = '0;
                    cycle_cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (req_fire) begin
                    if (seq_q == LAST_SEQ) begin
                        state_d = S_DRAIN;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = S_ISSUE;
                else               gap_d   = gap_q - 8'd1;
            end
            S_DRAIN: begin
                if (outstanding_q == 8'd0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Message is rebuilt from the next sequence/sweep position, so it only
        // moves on an accepted request or a new run and holds under stall.
        // The low OFFSET_BITS address bits (word offset and byte select) are zero.
        addr_d = '0;
        addr_d[OFFSET_BITS +: IDX_BITS]            = idx_d;
        addr_d[OFFSET_BITS + IDX_BITS +: TAG_BITS] = tag_d;
        type_d = (mode_d && !seq_d[0]) ? 2'd1 : 2'd0;
        msg_d  = {type_d, seq_d[7:0], addr_d, 2'd0, 16'd0, seq_d};
    end

    assign bus.cachereq_val  = req_val;
    assign bus.cachereq_msg  = msg_q;
    assign bus.cacheresp_rdy = resp_rdy;
    assign busy      = busy_w;
    assign done      = (state_q == S_DONE);
    assign req_cnt   = req_cnt_q;
    assign resp_cnt  = resp_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cache_req_traffic_gen.sv
// Directed bench for cache_req_traffic_gen with a small in-order cache model.
module tb_cache_req_traffic_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic        busy;
    logic        done;
    logic [15:0] req_cnt;
    logic [15:0] resp_cnt;
    logic [7:0]  err_cnt;
    logic [31:0] cycle_cnt;

    cache_req_if bus();

    cache_req_traffic_gen #(
        .NUM_REQ(50), .MAX_OUTSTANDING(4), .GAP(3), .OFFSET_BITS(4),
        .IDX_BITS(3), .TAG_BITS(3), .TAGS_PER_IDX(4), .IDX_WRAP(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .bus(bus),
        .busy(busy), .done(done), .req_cnt(req_cnt), .resp_cnt(resp_cnt),
        .err_cnt(err_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Cache model state: pending opaques with acceptance cycle, response control.
    logic [7:0]  mq[$];
    int          mts[$];
    logic [75:0] req_log[$];
    int          cyc = 0;
    int          credits = 0;
    bit          auto_rsp = 1'b0;

    // In-order cache: returns each opaque one cycle after it is old enough,
    // either freely (auto_rsp) or one per granted credit.
    initial begin
        bus.cacheresp_val = 1'b0;
        bus.cacheresp_msg = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                mq.delete();
                mts.delete();
            end else begin
                if (bus.cacheresp_val && bus.cacheresp_rdy && mq.size() > 0) begin
                    void'(mq.pop_front());
                    void'(mts.pop_front());
                    if (credits > 0) credits--;
                end
                if (bus.cachereq_val && bus.cachereq_rdy) begin
                    mq.push_back(bus.cachereq_msg[73:66]);
                    mts.push_back(cyc);
                    req_log.push_back(bus.cachereq_msg);
                end
            end
            #2;
            if (!reset && mq.size() > 0 && (auto_rsp || credits > 0) && (cyc - mts[0] >= 1)) begin
                bus.cacheresp_val = 1'b1;
                bus.cacheresp_msg = {2'd0, mq[0], 2'd0, 24'd0, mq[0]};
            end else begin
                bus.cacheresp_val = 1'b0;
                bus.cacheresp_msg = '0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected request i: tag = i%4 at addr bit 7, idx = (i/4)%4 at addr bit 4.
    function automatic logic [75:0] exp_msg(input int i, input bit m);
        logic [31:0] a;
        logic [1:0]  t;
        a = 32'((i % 4) * 128 + ((i / 4) % 4) * 16);
        t = (m && (i % 2 == 0)) ? 2'd1 : 2'd0;
        return {t, 8'(i), a, 2'd0, 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_run(input bit m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done timeout done=%0b req_cnt=%0d", done, req_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        tick(); tick();
        checks++; if (bus.cachereq_val !== 1'b0) begin errors++; $display("FAIL rst_val got %0b exp 0", bus.cachereq_val); end
        checks++; if (bus.cachereq_msg !== 76'd0) begin errors++; $display("FAIL rst_msg got %0h exp 0", bus.cachereq_msg); end
        checks++; if (bus.cacheresp_rdy !== 1'b0) begin errors++; $display("FAIL rst_resp_rdy got %0b exp 0", bus.cacheresp_rdy); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got %b exp 00", {busy, done}); end
        checks++; if ({req_cnt, resp_cnt, err_cnt, cycle_cnt} !== 72'd0) begin errors++; $display("FAIL rst_counters got %0h exp 0", {req_cnt, resp_cnt, err_cnt, cycle_cnt}); end
        start = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wins_start busy got %0b exp 0", busy); end
        start = 1'b0; reset = 1'b0;
        tick();
    endtask

    task automatic test_read_sweep();
        do_reset();
        auto_rsp = 1'b1; credits = 0; bus.cachereq_rdy = 1'b1;
        req_log.delete();
        start_run(1'b0);
        wait_done(400);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy got %0b exp 0", busy); end
        checks++; if (req_cnt !== 16'd50) begin errors++; $display("FAIL t1_req_cnt got %0d exp 50", req_cnt); end
        checks++; if (resp_cnt !== 16'd50) begin errors++; $display("FAIL t1_resp_cnt got %0d exp 50", resp_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL t1_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (cycle_cnt !== 32'd200) begin errors++; $display("FAIL t1_cycle_cnt got %0d exp 200", cycle_cnt); end
        checks++; if (req_log.size() !== 50) begin errors++; $display("FAIL t1_log_size got %0d exp 50", req_log.size()); end
        for (int i = 0; i < req_log.size() && i < 50; i++) begin
            checks++;
            if (req_log[i] !== exp_msg(i, 1'b0)) begin
                errors++;
                $display("FAIL t1_msg[%0d] got %0h exp %0h", i, req_log[i], exp_msg(i, 1'b0));
            end
        end
        checks++; if (req_log.size() > 4 && req_log[4][65:34] !== 32'h010) begin errors++; $display("FAIL t1_addr4 got %0h exp 10", req_log[4][65:34]); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({done, cycle_cnt} !== {1'b1, 32'd200}) begin errors++; $display("FAIL t1_done_hold got %0b/%0d exp 1/200", done, cycle_cnt); end
    endtask

    task automatic test_stall();
        logic [75:0] m0;
        do_reset();
        auto_rsp = 1'b1; credits = 0; bus.cachereq_rdy = 1'b0;
        start_run(1'b1);
        checks++; if (bus.cachereq_val !== 1'b1) begin errors++; $display("FAIL t2_val got %0b exp 1", bus.cachereq_val); end
        m0 = exp_msg(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.cachereq_val, bus.cachereq_msg, req_cnt} !== {1'b1, m0, 16'd0}) begin
                errors++;
                $display("FAIL t2_stall[%0d] got val=%0b msg=%0h req=%0d exp val=1 msg=%0h req=0", i, bus.cachereq_val, bus.cachereq_msg, req_cnt, m0);
            end
        end
        bus.cachereq_rdy = 1'b1;
        tick();
        checks++; if (req_cnt !== 16'd1) begin errors++; $display("FAIL t2_fire req_cnt got %0d exp 1", req_cnt); end
        checks++; if (bus.cachereq_msg !== exp_msg(1, 1'b1)) begin errors++; $display("FAIL t2_next_msg got %0h exp %0h", bus.cachereq_msg, exp_msg(1, 1'b1)); end
    endtask

    task automatic test_outstanding();
        do_reset();
        auto_rsp = 1'b0; credits = 0; bus.cachereq_rdy = 1'b1;
        start_run(1'b0);
        for (int i = 0; i < 40; i++) tick();
        checks++; if ({req_cnt, bus.cachereq_val, busy} !== {16'd4, 1'b0, 1'b1}) begin errors++; $display("FAIL t3_cap got req=%0d val=%0b busy=%0b exp 4/0/1", req_cnt, bus.cachereq_val, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (req_cnt !== 16'd4) begin errors++; $display("FAIL t3_start_busy req_cnt got %0d exp 4", req_cnt); end
        credits = 1;
        for (int i = 0; i < 40; i++) tick();
        checks++; if ({req_cnt, resp_cnt, bus.cachereq_val} !== {16'd5, 16'd1, 1'b0}) begin errors++; $display("FAIL t3_one_more got req=%0d resp=%0d val=%0b exp 5/1/0", req_cnt, resp_cnt, bus.cachereq_val); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL t3_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        auto_rsp = 1'b0; credits = 0; bus.cachereq_rdy = 1'b1;
        start_run(1'b0);
        for (int i = 0; i < 30 && req_cnt != 16'd3; i++) tick();
        bus.cachereq_rdy = 1'b0;
        checks++; if (req_cnt !== 16'd3) begin errors++; $display("FAIL t5_three got %0d exp 3", req_cnt); end
        credits = 1;
        for (int i = 0; i < 20 && resp_cnt != 16'd1; i++) tick();
        for (int i = 0; i < 20 && !bus.cachereq_val; i++) tick();
        checks++; if ({bus.cachereq_val, resp_cnt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL t5_setup got val=%0b resp=%0d exp 1/1", bus.cachereq_val, resp_cnt); end
        bus.cachereq_rdy = 1'b1;
        credits = 1;
        tick();
        checks++; if ({req_cnt, resp_cnt} !== {16'd4, 16'd2}) begin errors++; $display("FAIL t5_both_fire got req=%0d resp=%0d exp 4/2", req_cnt, resp_cnt); end
        for (int i = 0; i < 40; i++) tick();
        checks++; if ({req_cnt, bus.cachereq_val} !== {16'd6, 1'b0}) begin errors++; $display("FAIL t5_outstanding got req=%0d val=%0b exp 6/0", req_cnt, bus.cachereq_val); end
    endtask

    task automatic test_mode_swap();
        logic [7:0] tmp;
        do_reset();
        auto_rsp = 1'b0; credits = 0; bus.cachereq_rdy = 1'b1;
        req_log.delete();
        start_run(1'b1);
        for (int i = 0; i < 30; i++) tick();
        checks++; if (req_cnt !== 16'd4 || mq.size() != 4) begin errors++; $display("FAIL t4_fill got req=%0d q=%0d exp 4/4", req_cnt, mq.size()); end
        if (mq.size() >= 2) begin
            tmp = mq[0]; mq[0] = mq[1]; mq[1] = tmp;
        end
        auto_rsp = 1'b1;
        wait_done(400);
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL t4_err_cnt got %0d exp 2", err_cnt); end
        checks++; if ({req_cnt, resp_cnt} !== {16'd50, 16'd50}) begin errors++; $display("FAIL t4_counts got %0d/%0d exp 50/50", req_cnt, resp_cnt); end
        for (int i = 0; i < req_log.size() && i < 8; i++) begin
            checks++;
            if (req_log[i] !== exp_msg(i, 1'b1)) begin
                errors++;
                $display("FAIL t4_msg[%0d] got %0h exp %0h", i, req_log[i], exp_msg(i, 1'b1));
            end
        end
    endtask

    task automatic test_reset_drain();
        do_reset();
        auto_rsp = 1'b1; credits = 0; bus.cachereq_rdy = 1'b1;
        start_run(1'b0);
        for (int i = 0; i < 300 && req_cnt != 16'd49; i++) tick();
        auto_rsp = 1'b0;
        for (int i = 0; i < 20 && req_cnt != 16'd50; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({req_cnt, busy, done} !== {16'd50, 1'b1, 1'b0}) begin errors++; $display("FAIL t6_in_drain got req=%0d busy=%0b done=%0b exp 50/1/0", req_cnt, busy, done); end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.cachereq_val, bus.cachereq_msg, bus.cacheresp_rdy, busy, done, req_cnt, resp_cnt, err_cnt, cycle_cnt} !== 152'd0) begin
            errors++;
            $display("FAIL t6_reset got val=%0b msg=%0h rdy=%0b busy=%0b done=%0b req=%0d resp=%0d err=%0d cyc=%0d exp all 0",
                     bus.cachereq_val, bus.cachereq_msg, bus.cacheresp_rdy, busy, done, req_cnt, resp_cnt, err_cnt, cycle_cnt);
        end
        reset = 1'b0;
        tick();
        auto_rsp = 1'b1;
        req_log.delete();
        start_run(1'b0);
        wait_done(400);
        checks++; if (req_log.size() == 0 || req_log[0] !== 76'd0) begin errors++; $display("FAIL t6_restart_msg got size=%0d exp seq0 addr 0", req_log.size()); end
        checks++; if ({req_cnt, resp_cnt, err_cnt} !== {16'd50, 16'd50, 8'd0}) begin errors++; $display("FAIL t6_rerun got %0d/%0d/%0d exp 50/50/0", req_cnt, resp_cnt, err_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        bus.cachereq_rdy = 1'b0;
        test_reset();
        test_read_sweep();
        test_stall();
        test_outstanding();
        test_same_cycle();
        test_mode_swap();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
